// File: rtl/oc8051_wb_pkg.sv
// Shared definitions for the oc8051 wishbone arbiter: grant-state encoding,
// fairness marker values, default parameters and the data-port byte-select decode.
package oc8051_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } state_e;

    // Which master was served most recently; the other one wins the next tie.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 5;

    function automatic logic [3:0] byte_sel(input logic [1:0] lane);
        logic [3:0] sel;
        case (lane)
            2'd0:    sel = 4'b0001;
            2'd1:    sel = 4'b0010;
            2'd2:    sel = 4'b0100;
            2'd3:    sel = 4'b1000;
            default: sel = 4'b0001;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/oc8051_wb_arbiter_if.sv
// Bus bundle around the arbiter: instruction port, data port and memory port.
// "slave" is the arbiter's own view; "master" is the surrounding CPU + memory.
interface oc8051_wb_arbiter_if;

    logic [15:0] iadr_i;
    logic        istb_i;
    logic        icyc_i;
    logic [31:0] idat_o;
    logic        iack_o;
    logic        ierr_o;

    logic [15:0] dadr_i;
    logic [7:0]  ddat_i;
    logic        dwe_i;
    logic        dstb_i;
    logic        dcyc_i;
    logic [7:0]  ddat_o;
    logic        dack_o;
    logic        derr_o;

    logic [15:0] madr_o;
    logic [31:0] mdat_o;
    logic        mwe_o;
    logic [3:0]  msel_o;
    logic        mstb_o;
    logic        mcyc_o;
    logic [31:0] mdat_i;
    logic        mack_i;

    modport slave (
        input  iadr_i, istb_i, icyc_i,
        output idat_o, iack_o, ierr_o,
        input  dadr_i, ddat_i, dwe_i, dstb_i, dcyc_i,
        output ddat_o, dack_o, derr_o,
        output madr_o, mdat_o, mwe_o, msel_o, mstb_o, mcyc_o,
        input  mdat_i, mack_i
    );

    modport master (
        output iadr_i, istb_i, icyc_i,
        input  idat_o, iack_o, ierr_o,
        output dadr_i, ddat_i, dwe_i, dstb_i, dcyc_i,
        input  ddat_o, dack_o, derr_o,
        input  madr_o, mdat_o, mwe_o, msel_o, mstb_o, mcyc_o,
        output mdat_i, mack_i
    );

endinterface

// File: rtl/oc8051_wb_lane.sv
// Byte-lane steering between the 8-bit data port and the 32-bit memory word.
module oc8051_wb_lane
    import oc8051_wb_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [7:0]  wbyte_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wword_o,
    output logic [7:0]  rbyte_o
);

    assign sel_o   = byte_sel(lane_i);
    assign wword_o = {4{wbyte_i}};

    // Extract the addressed byte of the read word; byte 0 is bits 7:0.
    always_comb begin
        case (lane_i)
            2'd0:    rbyte_o = rword_i[7:0];
            2'd1:    rbyte_o = rword_i[15:8];
            2'd2:    rbyte_o = rword_i[23:16];
            2'd3:    rbyte_o = rword_i[31:24];
            default: rbyte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/oc8051_wb_arbiter.sv
// Round-robin two-master wishbone arbiter sharing one 32-bit memory between the
// oc8051 instruction-fetch port and its byte-wide data port, with bus timeout.
module oc8051_wb_arbiter
    import oc8051_wb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    oc8051_wb_arbiter_if.slave   bus,
    output logic [1:0]           gnt_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ireq_s, dreq_s;
    logic              own_req_s, oth_req_s;
    logic              tmo_s;
    logic [3:0]        lane_sel_s;
    logic [31:0]       lane_wdat_s;
    logic [7:0]        lane_rbyte_s;

    logic [15:0]       madr_s;
    logic [31:0]       mdat_s;
    logic              mwe_s;
    logic [3:0]        msel_s;
    logic              mstb_s;

    assign ireq_s = bus.icyc_i & bus.istb_i;
    assign dreq_s = bus.dcyc_i & bus.dstb_i;

    // The timeout fires in the granted cycle that would otherwise be the TIMEOUT-th unacked one.
    assign tmo_s = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    oc8051_wb_lane u_lane (
        .lane_i  (bus.dadr_i[1:0]),
        .wbyte_i (bus.ddat_i),
        .rword_i (bus.mdat_i),
        .sel_o   (lane_sel_s),
        .wword_o (lane_wdat_s),
        .rbyte_o (lane_rbyte_s)
    );

    // Request of the current owner and of the waiting master.
    always_comb begin
        own_req_s = 1'b0;
        oth_req_s = 1'b0;
        case (state_q)
            ST_GNT_I: begin
                own_req_s = ireq_s;
                oth_req_s = dreq_s;
            end
            ST_GNT_D: begin
                own_req_s = dreq_s;
                oth_req_s = ireq_s;
            end
            default: begin
                own_req_s = 1'b0;
                oth_req_s = 1'b0;
            end
        endcase
    end

    // Next grant, fairness marker and timeout counter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ireq_s && dreq_s) begin
                    state_d = (last_q == LAST_D) ? ST_GNT_I : ST_GNT_D;
                end else if (ireq_s) begin
                    state_d = ST_GNT_I;
                end else if (dreq_s) begin
                    state_d = ST_GNT_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (!own_req_s) begin
                    state_d = ST_IDLE;
                    last_d  = (state_q == ST_GNT_D) ? LAST_D : LAST_I;
                    cnt_d   = '0;
                end else if (bus.mack_i || tmo_s) begin
                    last_d = (state_q == ST_GNT_D) ? LAST_D : LAST_I;
                    cnt_d  = '0;
                    if (oth_req_s) begin
                        state_d = (state_q == ST_GNT_I) ? ST_GNT_D : ST_GNT_I;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_D;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory-side drive follows the owner; everything is quiet when idle.
    always_comb begin
        madr_s = 16'h0000;
        mdat_s = 32'h0000_0000;
        mwe_s  = 1'b0;
        msel_s = 4'h0;
        mstb_s = 1'b0;
        case (state_q)
            ST_GNT_I: begin
                madr_s = bus.iadr_i;
                msel_s = 4'hF;
                mstb_s = ireq_s;
            end
            ST_GNT_D: begin
                madr_s = {bus.dadr_i[15:2], 2'b00};
                mdat_s = lane_wdat_s;
                mwe_s  = bus.dwe_i;
                msel_s = lane_sel_s;
                mstb_s = dreq_s;
            end
            default: begin
                mstb_s = 1'b0;
            end
        endcase
    end

    assign bus.madr_o = madr_s;
    assign bus.mdat_o = mdat_s;
    assign bus.mwe_o  = mwe_s;
    assign bus.msel_o = msel_s;
    assign bus.mstb_o = mstb_s;
    assign bus.mcyc_o = mstb_s;

    // Read data is forced low during reset so every output is quiet then.
    assign bus.idat_o = rst ? 32'h0000_0000 : bus.mdat_i;
    assign bus.ddat_o = rst ? 8'h00 : lane_rbyte_s;

    assign bus.iack_o = bus.mack_i & (state_q == ST_GNT_I) & ireq_s;
    assign bus.dack_o = bus.mack_i & (state_q == ST_GNT_D) & dreq_s;
    assign bus.ierr_o = tmo_s & ~bus.mack_i & (state_q == ST_GNT_I) & ireq_s;
    assign bus.derr_o = tmo_s & ~bus.mack_i & (state_q == ST_GNT_D) & dreq_s;

    assign gnt_o = {state_q == ST_GNT_D, state_q == ST_GNT_I};

endmodule

// File: tb/tb_oc8051_wb_arbiter.sv
// Self-checking bench for oc8051_wb_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the arbitration rules.
module tb_oc8051_wb_arbiter;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    int         n_checks = 0;
    int         n_errors = 0;

    oc8051_wb_arbiter_if bus();

    oc8051_wb_arbiter #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .gnt_o (gnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic i, input logic d);
        bus.icyc_i = i; bus.istb_i = i;
        bus.dcyc_i = d; bus.dstb_i = d;
    endtask

    task automatic idle_all();
        set_req(1'b0, 1'b0);
        bus.mack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1'b1, 1'b1);
        bus.mack_i = 1'b1; bus.mdat_i = 32'hCAFE_F00D;
        bus.iadr_i = 16'h0124; bus.dadr_i = 16'h0037; bus.ddat_i = 8'hA5; bus.dwe_i = 1'b1;
        tick(); tick();
        n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
        n_checks++;
        if ({bus.mstb_o, bus.mcyc_o, bus.mwe_o, bus.iack_o, bus.dack_o, bus.ierr_o, bus.derr_o} !== 7'b0) begin
            n_errors++; $display("FAIL reset_ctrl got %b want 0000000",
                {bus.mstb_o, bus.mcyc_o, bus.mwe_o, bus.iack_o, bus.dack_o, bus.ierr_o, bus.derr_o});
        end
        n_checks++;
        if ({bus.madr_o, bus.msel_o, bus.mdat_o, bus.idat_o, bus.ddat_o} !== 92'h0) begin
            n_errors++; $display("FAIL reset_data got madr=%h msel=%h mdat=%h idat=%h ddat=%h want all 0",
                bus.madr_o, bus.msel_o, bus.mdat_o, bus.idat_o, bus.ddat_o);
        end
        // Bring up a data transfer, then reset it while the slave acks.
        set_req(1'b0, 1'b1); bus.mack_i = 1'b0; bus.dwe_i = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++; if (gnt !== 2'b10) begin n_errors++; $display("FAIL midrst_pre_gnt got %b want 10", gnt); end
        set_req(1'b1, 1'b1); bus.mack_i = 1'b1;
        #1;
        n_checks++; if (bus.dack_o !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_dack got %b want 1", bus.dack_o); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({gnt, bus.mstb_o, bus.dack_o, bus.derr_o} !== 5'b0) begin
            n_errors++; $display("FAIL midrst_drop got gnt=%b mstb=%b dack=%b derr=%b want all 0",
                gnt, bus.mstb_o, bus.dack_o, bus.derr_o);
        end
        bus.mack_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL midrst_first_gnt got %b want 01", gnt); end
        idle_all();
    endtask

    task automatic test_iread();
        bus.iadr_i = 16'h0124; set_req(1'b1, 1'b0); bus.mack_i = 1'b0;
        tick();
        n_checks++;
        if ({gnt, bus.madr_o, bus.msel_o, bus.mwe_o, bus.mstb_o} !== {2'b01, 16'h0124, 4'hF, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL iread_bus got gnt=%b madr=%h msel=%h mwe=%b mstb=%b want 01 0124 f 0 1",
                gnt, bus.madr_o, bus.msel_o, bus.mwe_o, bus.mstb_o);
        end
        tick();
        n_checks++; if (bus.iack_o !== 1'b0) begin n_errors++; $display("FAIL iread_early_ack got %b want 0", bus.iack_o); end
        tick();
        bus.mack_i = 1'b1; bus.mdat_i = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({bus.iack_o, bus.ierr_o, bus.idat_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL iread_ack got iack=%b ierr=%b idat=%h want 1 0 deadbeef",
                bus.iack_o, bus.ierr_o, bus.idat_o);
        end
        tick();
        set_req(1'b0, 1'b0); bus.mack_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.iack_o, gnt} !== 3'b000) begin
            n_errors++; $display("FAIL iread_after got iack=%b gnt=%b want 0 00", bus.iack_o, gnt);
        end
    endtask

    task automatic test_dwrite_read();
        bus.dadr_i = 16'h0037; bus.ddat_i = 8'hA5; bus.dwe_i = 1'b1; set_req(1'b0, 1'b1);
        tick();
        n_checks++;
        if ({gnt, bus.madr_o, bus.msel_o, bus.mdat_o, bus.mwe_o} !== {2'b10, 16'h0034, 4'b1000, 32'hA5A5_A5A5, 1'b1}) begin
            n_errors++; $display("FAIL dwrite_bus got gnt=%b madr=%h msel=%b mdat=%h mwe=%b want 10 0034 1000 a5a5a5a5 1",
                gnt, bus.madr_o, bus.msel_o, bus.mdat_o, bus.mwe_o);
        end
        bus.mack_i = 1'b1;
        #1;
        n_checks++; if (bus.dack_o !== 1'b1) begin n_errors++; $display("FAIL dwrite_ack got %b want 1", bus.dack_o); end
        tick();
        set_req(1'b0, 1'b0); bus.mack_i = 1'b0;
        #1;
        n_checks++; if (gnt !== 2'b00) begin n_errors++; $display("FAIL dwrite_after got %b want 00", gnt); end
        bus.dadr_i = 16'h0036; bus.dwe_i = 1'b0; set_req(1'b0, 1'b1);
        tick();
        bus.mack_i = 1'b1; bus.mdat_i = 32'h1122_3344;
        #1;
        n_checks++;
        if ({bus.ddat_o, bus.dack_o, bus.msel_o, bus.madr_o, bus.mwe_o} !== {8'h22, 1'b1, 4'b0100, 16'h0034, 1'b0}) begin
            n_errors++; $display("FAIL dread got ddat=%h dack=%b msel=%b madr=%h mwe=%b want 22 1 0100 0034 0",
                bus.ddat_o, bus.dack_o, bus.msel_o, bus.madr_o, bus.mwe_o);
        end
        tick();
        set_req(1'b0, 1'b0); bus.mack_i = 1'b0;
        #1;
        n_checks++; if ({gnt, bus.dack_o} !== 3'b000) begin n_errors++; $display("FAIL dread_after got gnt=%b dack=%b want 00 0", gnt, bus.dack_o); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        logic       ack;
        bus.iadr_i = 16'h0200; bus.dadr_i = 16'h0301; bus.dwe_i = 1'b0;
        set_req(1'b1, 1'b1); bus.mack_i = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            ack = (k % 2) == 1;
            bus.mack_i = ack;
            #1;
            exp_gnt = (((k / 2) % 2) == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if ({gnt, bus.mstb_o, bus.iack_o, bus.dack_o} !== {exp_gnt, 1'b1, ack & exp_gnt[0], ack & exp_gnt[1]}) begin
                n_errors++; $display("FAIL b2b_cycle%0d got gnt=%b mstb=%b iack=%b dack=%b want %b 1 %b %b", k,
                    gnt, bus.mstb_o, bus.iack_o, bus.dack_o, exp_gnt, ack & exp_gnt[0], ack & exp_gnt[1]);
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_timeout();
        bus.dadr_i = 16'h0010; bus.dwe_i = 1'b0; set_req(1'b0, 1'b1); bus.mack_i = 1'b0;
        tick();
        set_req(1'b1, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            #1;
            n_checks++;
            if ({gnt, bus.derr_o, bus.dack_o, bus.ierr_o} !== {2'b10, c == 4, 1'b0, 1'b0}) begin
                n_errors++; $display("FAIL tmo_cycle%0d got gnt=%b derr=%b dack=%b ierr=%b want 10 %b 0 0",
                    c, gnt, bus.derr_o, bus.dack_o, bus.ierr_o, c == 4);
            end
        end
        tick();
        n_checks++;
        if ({gnt, bus.derr_o} !== 3'b010) begin
            n_errors++; $display("FAIL tmo_next_gnt got gnt=%b derr=%b want 01 0", gnt, bus.derr_o);
        end
        bus.mack_i = 1'b1;
        #1;
        n_checks++; if (bus.iack_o !== 1'b1) begin n_errors++; $display("FAIL tmo_iack got %b want 1", bus.iack_o); end
        tick();
        bus.mack_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            bus.mack_i = (c == 4);
            #1;
            n_checks++;
            if ({gnt, bus.dack_o, bus.derr_o} !== {2'b10, c == 4, 1'b0}) begin
                n_errors++; $display("FAIL tmo_ackwins_cycle%0d got gnt=%b dack=%b derr=%b want 10 %b 0",
                    c, gnt, bus.dack_o, bus.derr_o, c == 4);
            end
        end
        tick();
        bus.mack_i = 1'b0;
        #1;
        n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL tmo_ackwins_next got %b want 01", gnt); end
        idle_all();
    endtask

    // Random traffic against a model: owner 0 = none, 1 = instruction, 2 = data.
    task automatic test_random();
        int m_own, m_last, m_wait, lane, other;
        logic ireq, dreq, own_req, tmo_now;
        logic [1:0]  e_gnt;
        logic [15:0] e_madr;
        logic [3:0]  e_msel;
        logic [31:0] e_mdat;
        logic        e_mwe;
        logic [7:0]  e_ddat;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_own = 0; m_last = 2; m_wait = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            bus.icyc_i = ($urandom % 8) != 0; bus.istb_i = ($urandom % 8) != 0;
            bus.dcyc_i = ($urandom % 8) != 0; bus.dstb_i = ($urandom % 8) != 0;
            bus.iadr_i = 16'($urandom); bus.dadr_i = 16'($urandom);
            bus.ddat_i = 8'($urandom);  bus.dwe_i = 1'($urandom);
            bus.mdat_i = $urandom;      bus.mack_i = ($urandom % 4) == 0;
            #1;
            ireq = bus.icyc_i & bus.istb_i;
            dreq = bus.dcyc_i & bus.dstb_i;
            lane = int'(bus.dadr_i) % 4;
            own_req = (m_own == 1) ? ireq : (m_own == 2) ? dreq : 1'b0;
            tmo_now = own_req && !bus.mack_i && (m_wait == TMO - 1);
            e_gnt  = 2'(m_own);
            e_madr = (m_own == 1) ? bus.iadr_i : (m_own == 2) ? (bus.dadr_i & 16'hFFFC) : 16'h0000;
            e_msel = (m_own == 1) ? 4'hF : (m_own == 2) ? 4'(1 << lane) : 4'h0;
            e_mdat = (m_own == 2) ? 32'(bus.ddat_i) * 32'h0101_0101 : 32'h0;
            e_mwe  = (m_own == 2) ? bus.dwe_i : 1'b0;
            e_ddat = 8'(bus.mdat_i >> (8 * lane));
            n_checks++;
            if ({gnt, bus.mstb_o, bus.mcyc_o, bus.mwe_o, bus.msel_o, bus.madr_o, bus.mdat_o} !==
                {e_gnt, own_req, own_req, e_mwe, e_msel, e_madr, e_mdat}) begin
                n_errors++; $display("FAIL rand_slave cyc%0d got gnt=%b stb=%b cyc=%b we=%b sel=%h adr=%h dat=%h want %b %b %b %b %h %h %h",
                    n, gnt, bus.mstb_o, bus.mcyc_o, bus.mwe_o, bus.msel_o, bus.madr_o, bus.mdat_o,
                    e_gnt, own_req, own_req, e_mwe, e_msel, e_madr, e_mdat);
            end
            n_checks++;
            if ({bus.iack_o, bus.ierr_o, bus.dack_o, bus.derr_o} !==
                {(m_own == 1) && own_req && bus.mack_i, (m_own == 1) && tmo_now,
                 (m_own == 2) && own_req && bus.mack_i, (m_own == 2) && tmo_now}) begin
                n_errors++; $display("FAIL rand_resp cyc%0d got iack=%b ierr=%b dack=%b derr=%b owner=%0d wait=%0d mack=%b",
                    n, bus.iack_o, bus.ierr_o, bus.dack_o, bus.derr_o, m_own, m_wait, bus.mack_i);
            end
            n_checks++;
            if ({bus.idat_o, bus.ddat_o} !== {bus.mdat_i, e_ddat}) begin
                n_errors++; $display("FAIL rand_rdata cyc%0d got idat=%h ddat=%h want %h %h",
                    n, bus.idat_o, bus.ddat_o, bus.mdat_i, e_ddat);
            end
            if (m_own == 0) begin
                if (ireq && dreq) m_own = 3 - m_last;
                else if (ireq)    m_own = 1;
                else if (dreq)    m_own = 2;
                else              m_own = 0;
                m_wait = 0;
            end else if (!own_req) begin
                m_last = m_own; m_own = 0; m_wait = 0;
            end else if (bus.mack_i || tmo_now) begin
                other  = 3 - m_own;
                m_last = m_own;
                m_own  = ((other == 1) ? ireq : dreq) ? other : 0;
                m_wait = 0;
            end else begin
                m_wait = m_wait + 1;
            end
        end
        idle_all();
    endtask

    initial begin
        rst = 1'b1;
        bus.icyc_i = 1'b0; bus.istb_i = 1'b0; bus.iadr_i = 16'h0000;
        bus.dcyc_i = 1'b0; bus.dstb_i = 1'b0; bus.dadr_i = 16'h0000;
        bus.ddat_i = 8'h00; bus.dwe_i = 1'b0;
        bus.mdat_i = 32'h0; bus.mack_i = 1'b0;
        test_reset();
        test_iread();
        test_dwrite_read();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
